// File: rtl/mesm6_pkg.sv
// Shared widths and fetch-state encoding for the MESM-6 instruction fetch unit.
package mesm6_pkg;

  localparam int unsigned WORD_W  = 48;
  localparam int unsigned WADDR_W = 15;
  localparam int unsigned OP_W    = 24;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/mesm6_ifq.sv
// Circular prefetch queue of {word address, 48-bit word} entries with flush and
// an associative address match used for self-modifying-code snooping.
module mesm6_ifq
  import mesm6_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WADDR_W-1:0]    push_addr,
  input  logic [WORD_W-1:0]     push_data,
  input  logic                  pop,
  input  logic [WADDR_W-1:0]    match_addr,
  output logic [WADDR_W-1:0]    head_addr,
  output logic [WORD_W-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                  match_hit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WADDR_W-1:0] addr_mem [DEPTH];
  logic [WORD_W-1:0]  data_mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // A slot is live when its distance from head is below count (all slots when full).
  always_comb begin
    match_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW'(i) - head) < count[PW-1:0] || count[PW]) && (addr_mem[i] == match_addr)) begin
        match_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesm6_ifetch.sv
// MESM-6 instruction fetch: hit/advance/miss decode over the prefetch queue and
// the instruction-bus request FSM, with snoop-triggered flush.
module mesm6_ifetch
  import mesm6_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PREFETCH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         pc,
  input  logic                pc_valid,
  output logic [OP_W-1:0]     opcode,
  output logic                op_valid,
  input  logic                snoop_we,
  input  logic [WADDR_W-1:0]  snoop_addr,
  output logic                ibus_fetch,
  output logic [WADDR_W-1:0]  ibus_addr,
  input  logic [WORD_W-1:0]   ibus_input,
  input  logic                ibus_done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state;
  logic [WADDR_W-1:0] fetch_addr;
  logic [WADDR_W-1:0] fetch_addr_nxt;
  logic [WADDR_W-1:0] pc_word;
  logic [WADDR_W-1:0] head_addr;
  logic [WORD_W-1:0]  head_data;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after;
  logic               q_match;
  logic               hit;
  logic               advance;
  logic               pending;
  logic               miss;
  logic               snoop_hit;
  logic               flush;
  logic               push;
  logic               pop;
  logic               can_issue;

  assign pc_word = pc[15:1];

  always_comb begin
    hit     = (count != '0) && (head_addr == pc_word);
    advance = pc_valid && (count >= CNT_W'(2)) && (pc_word == head_addr + 15'd1);
    // Waiting for the word already on the bus is not a miss.
    pending = (state == StFetch) && (ibus_addr == pc_word);
    miss    = pc_valid && !hit && !advance && !pending;
    snoop_hit = snoop_we && (q_match || ((state == StFetch) && (ibus_addr == snoop_addr)));
    flush   = miss || snoop_hit;
    push    = (state == StFetch) && ibus_done && !flush;
    pop     = advance && !flush;
    count_after = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    if (flush) begin
      fetch_addr_nxt = pc_word;
    end else if (push) begin
      fetch_addr_nxt = fetch_addr + 15'd1;
    end else begin
      fetch_addr_nxt = fetch_addr;
    end
    // Issue decisions look at the queue as it will be after this edge.
    if (PREFETCH != 0) begin
      can_issue = count_after < CNT_W'(DEPTH);
    end else begin
      can_issue = (count_after == '0) && pc_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      ibus_fetch <= 1'b0;
      ibus_addr  <= '0;
      fetch_addr <= '0;
    end else begin
      fetch_addr <= fetch_addr_nxt;
      unique case (state)
        StIdle: begin
          if (can_issue) begin
            state      <= StFetch;
            ibus_fetch <= 1'b1;
            ibus_addr  <= fetch_addr_nxt;
          end
        end
        StFetch, StDiscard: begin
          if (ibus_done) begin
            if (can_issue) begin
              state     <= StFetch;
              ibus_addr <= fetch_addr_nxt;
            end else begin
              state      <= StIdle;
              ibus_fetch <= 1'b0;
            end
          end else if (flush) begin
            state <= StDiscard;
          end
        end
        default: begin
          state      <= StIdle;
          ibus_fetch <= 1'b0;
        end
      endcase
    end
  end

  assign op_valid = hit;
  assign opcode   = !hit ? '0 : (pc[0] ? head_data[OP_W-1:0] : head_data[WORD_W-1:OP_W]);

  mesm6_ifq #(
    .DEPTH(DEPTH)
  ) u_ifq (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_addr (ibus_addr),
    .push_data (ibus_input),
    .pop       (pop),
    .match_addr(snoop_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .match_hit (q_match)
  );

endmodule

// File: doc/mesm6_ifetch.md
MESM6_IFETCH -- requirements
Module: mesm6_ifetch

Interface
REQ-001 SHALL have parameter DEPTH, 4, prefetch queue depth in 48-bit words (power of 2, 2..16).
REQ-002 SHALL have parameter PREFETCH, 1, 1 = sequential prefetch ahead of pc; 0 = fetch on miss only (single-word opcode cache).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc  input  16  half-word program counter; bit 0 selects right instruction.
REQ-006 SHALL have port pc_valid  input  1  core requests the opcode at pc this cycle.
REQ-007 SHALL have port opcode  output  24  selected instruction: word[47:24] if pc[0]=0, else word[23:0].
REQ-008 SHALL have port op_valid  output  1  opcode is valid for the current pc.
REQ-009 SHALL have port snoop_we  input  1  data-bus write in progress, used for self-modifying-code detection.
REQ-010 SHALL have port snoop_addr  input  15  word address of that write.
REQ-011 SHALL have port ibus_fetch  output  1  instruction read request (registered).
REQ-012 SHALL have port ibus_addr  output  15  word address (registered), stable while ibus_fetch=1.
REQ-013 SHALL have port ibus_input  input  48  fetched word, valid when ibus_done=1.
REQ-014 SHALL have port ibus_done  input  1  fetch completes this cycle.

Function
REQ-015 Queue SHALL hold up to DEPTH entries {word address, 48-bit data}, in strictly consecutive ascending word addresses (mod 2^15) from the head.
REQ-016 Hit: op_valid SHALL be 1 combinationally when the queue is non-empty and head address == pc[15:1]; opcode is taken from the head.
REQ-017 Advance: when pc_valid and pc[15:1] == head address+1 and a second entry exists, the head SHALL be popped at the clock edge; op_valid=1 in the next cycle.
REQ-018 Miss: when pc_valid and neither REQ-016 nor REQ-017 applies, the queue SHALL be flushed at the clock edge and fetch_addr set to pc[15:1].
REQ-019 FSM states SHALL be IDLE (no request outstanding), FETCH (ibus_fetch=1, data kept), DISCARD (ibus_fetch=1, data dropped on done).
REQ-020 IDLE->FETCH when free slots minus outstanding > 0 (PREFETCH=1) or the queue is empty and pc_valid (PREFETCH=0); ibus_addr <= fetch_addr.
REQ-021 FETCH with ibus_done: push {ibus_addr, ibus_input}, fetch_addr increments by 1 with wrap 32767->0, then go to FETCH again (back-to-back, new address) if REQ-020 still holds, else IDLE.
REQ-022 Flush (miss or snoop) while in FETCH without ibus_done SHALL go to DISCARD; ibus_fetch and ibus_addr stay unchanged until ibus_done; then go to FETCH at the new fetch_addr.
REQ-023 Flush in the same cycle as ibus_done SHALL drop that data; a new fetch is issued next cycle at the new address.
REQ-024 Snoop: snoop_we with snoop_addr equal to any valid entry address or an outstanding ibus_addr SHALL flush the queue and restart at pc[15:1].
REQ-025 Push and pop in the same cycle SHALL both take effect; count stays unchanged.
REQ-026 A push that would exceed DEPTH SHALL never be issued; the number of entries plus outstanding requests SHALL never exceed DEPTH.
REQ-027 Miss latency with zero-wait memory: miss in cycle t, ibus_fetch=1 in t+1, op_valid=1 in t+2.

Reset
REQ-028 Reset SHALL clear the queue, set FSM=IDLE, ibus_fetch=0, ibus_addr=0, fetch_addr=0, op_valid=0, opcode=0.
REQ-029 Reset during an outstanding fetch SHALL drop ibus_fetch at the next edge and ignore any later ibus_done until a new request.

Structure
REQ-030 FSM state enum and the widths WORD_W=48, WADDR_W=15, and OP_W=24 SHALL live in the shared package mesm6_pkg.
REQ-031 Queue storage and pointers SHALL be one sub-module mesm6_ifq (circular buffer, head/tail/count, flush); the FSM and hit logic stay in mesm6_ifetch.

Verification
REQ-032 Cold start: reset, pc=0x0000 valid, zero-wait memory returns word 0x111111_222222 -> ibus_addr=0, op_valid at cycle 2, opcode=0x111111; pc=0x0001 -> opcode=0x222222, no new miss.
REQ-033 Streaming, DEPTH=4, PREFETCH=1: pc steps 0..15 -> ibus_addr 0,1,2,... issued back-to-back; outstanding plus queued never exceeds 4; op_valid continuous after the first fill.
REQ-034 Branch during wait-state fetch: ibus_done delayed 3 cycles, pc jumps to 0x0200 -> DISCARD; old data dropped; next ibus_addr=0x0100; opcode from the new word.
REQ-035 Wrap: pc=0xFFFE -> fetches 0x7FFF then 0x0000; advancing to pc=0x0000 hits without a miss.
REQ-036 Snoop: queue holds 0x10..0x13, snoop_we with addr 0x12 -> flush, refetch at pc[15:1]; snoop addr 0x40 -> no effect.
REQ-037 PREFETCH=0: sequential pc -> exactly one fetch per new word, never more than 1 entry queued.
